dds_nco: RTL

//  Numerically controlled oscillator that consumes phase increment K from freq_select and produces quadrature LO samples (cos/sin) for the down-mixer.

---
 rtl/dds_nco.sv | 101 ++++++++++
 1 files changed

// File: rtl/dds_nco.sv
// dds_nco: quadrature NCO with a synchronised, stability-filtered tuning word and phase-continuous retune.
// Pipeline: accumulator -> quadrant fold -> quarter-wave ROM -> sign restore.
module dds_nco #(
  parameter int width_dds      = 32,
  parameter int width_lut_addr = 8,
  parameter int width_out      = 12,
  parameter int stable_cycles  = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [width_dds-1:0]        K,
  input  logic                        phase_clr,
  output logic signed [width_out-1:0] lo_cos,
  output logic signed [width_out-1:0] lo_sin,
  output logic                        lo_valid,
  output logic [width_dds-1:0]        phase,
  output logic                        retune
);
  localparam int N = 2 ** width_lut_addr;
  localparam int CW = $clog2(stable_cycles);
  localparam logic [CW-1:0] CMAX = CW'(stable_cycles - 1);
  localparam real PI = 3.14159265358979323846;
  localparam real AMP = real'(2 ** (width_out - 1) - 1);

  // Half-LSB sample offset makes lut[~a] the exact mirror of lut[a].
  function automatic logic [width_out-1:0] lut_val(input int i);
    return width_out'($rtoi(AMP * $sin(PI / 2.0 * (real'(i) + 0.5) / real'(N)) + 0.5));
  endfunction

  logic [width_out-1:0] lut [N];
  for (genvar i = 0; i < N; i++) begin : g_lut
    assign lut[i] = lut_val(i);
  end

  logic [width_dds-1:0] k_s1_q, k_s2_q, k_s3_q, k_reg_q, k_reg_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic retune_q, load;
  logic [1:0] qs, qc;
  logic [width_lut_addr-1:0] a, s_addr_q, c_addr_q;
  logic s_neg1_q, c_neg1_q, s_neg2_q, c_neg2_q;
  logic [width_out-1:0] s_mag_q, c_mag_q;
  logic signed [width_out-1:0] lo_sin_q, lo_cos_q;
  logic [2:0] vld_q;

  always_comb begin
    qs = acc_q[width_dds-1 -: 2];
    qc = qs + 2'd1;
    a = acc_q[width_dds-3 -: width_lut_addr];
    load = (cnt_q == CMAX) && (k_s2_q == k_s3_q) && (k_s2_q != k_reg_q);
    cnt_d = (k_s2_q != k_s3_q) ? '0 : (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
    k_reg_d = load ? k_s2_q : k_reg_q;
    acc_d = phase_clr ? '0 : acc_q + k_reg_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      k_s1_q   <= '0;
      k_s2_q   <= '0;
      k_s3_q   <= '0;
      cnt_q    <= '0;
      k_reg_q  <= '0;
      retune_q <= 1'b0;
      acc_q    <= '0;
      s_addr_q <= '0;
      c_addr_q <= '0;
      s_neg1_q <= 1'b0;
      c_neg1_q <= 1'b0;
      s_mag_q  <= '0;
      c_mag_q  <= '0;
      s_neg2_q <= 1'b0;
      c_neg2_q <= 1'b0;
      lo_sin_q <= '0;
      lo_cos_q <= '0;
      vld_q    <= '0;
    end else begin
      k_s1_q   <= K;
      k_s2_q   <= k_s1_q;
      k_s3_q   <= k_s2_q;
      cnt_q    <= cnt_d;
      k_reg_q  <= k_reg_d;
      retune_q <= load;
      acc_q    <= acc_d;
      s_addr_q <= qs[0] ? ~a : a;
      c_addr_q <= qc[0] ? ~a : a;
      s_neg1_q <= qs[1];
      c_neg1_q <= qc[1];
      s_mag_q  <= lut[s_addr_q];
      c_mag_q  <= lut[c_addr_q];
      s_neg2_q <= s_neg1_q;
      c_neg2_q <= c_neg1_q;
      lo_sin_q <= s_neg2_q ? -s_mag_q : s_mag_q;
      lo_cos_q <= c_neg2_q ? -c_mag_q : c_mag_q;
      vld_q    <= {vld_q[1:0], 1'b1};
    end

  assign phase    = acc_q;
  assign retune   = retune_q;
  assign lo_sin   = lo_sin_q;
  assign lo_cos   = lo_cos_q;
  assign lo_valid = vld_q[2];
endmodule
